// File: rtl/mips_defs.sv
// Shared opcode and width definitions for the MIPS pipeline.
package mips_defs;

    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;

    localparam logic [31:0] NOP = 32'h0;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry register file, two async read ports and one write port.
// $0 is hardwired to zero; a same-cycle write is bypassed to the readers.
module register_file
    import mips_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [REG_ADDR_WIDTH-1:0] i_RA1,
    input  logic [REG_ADDR_WIDTH-1:0] i_RA2,
    input  logic                      i_WE,
    input  logic [REG_ADDR_WIDTH-1:0] i_WA,
    input  logic [DATA_WIDTH-1:0]     i_WD,
    output logic [DATA_WIDTH-1:0]     o_RD1,
    output logic [DATA_WIDTH-1:0]     o_RD2
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic                  wr_en;

    assign wr_en = i_WE && (i_WA != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[i_WA] = i_WD;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        o_RD1 = regs_q[i_RA1];
        o_RD2 = regs_q[i_RA2];
        if (wr_en && (i_WA == i_RA1)) begin
            o_RD1 = i_WD;
        end
        if (wr_en && (i_WA == i_RA2)) begin
            o_RD2 = i_WD;
        end
        if (i_RA1 == '0) begin
            o_RD1 = '0;
        end
        if (i_RA2 == '0) begin
            o_RD2 = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, register read, sign extension and
// early beq/j resolution feeding the fetch PC mux.
module decode_stage
    import mips_defs::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [INSTR_WIDTH-1:0]    i_InstrF,
    input  logic [ADDRESS_WIDTH-1:0]  i_PCPlus4F,
    input  logic                      i_StallD,
    input  logic                      i_BranchD,
    input  logic                      i_JumpD,
    input  logic                      i_ForwardAD,
    input  logic                      i_ForwardBD,
    input  logic [DATA_WIDTH-1:0]     i_ALUOutM,
    input  logic                      i_RegWriteW,
    input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegW,
    input  logic [DATA_WIDTH-1:0]     i_ResultW,
    output logic [5:0]                o_OpD,
    output logic [5:0]                o_FunctD,
    output logic [REG_ADDR_WIDTH-1:0] o_RsD,
    output logic [REG_ADDR_WIDTH-1:0] o_RtD,
    output logic [REG_ADDR_WIDTH-1:0] o_RdD,
    output logic [DATA_WIDTH-1:0]     o_SignImmD,
    output logic [DATA_WIDTH-1:0]     o_RD1D,
    output logic [DATA_WIDTH-1:0]     o_RD2D,
    output logic [ADDRESS_WIDTH-1:0]  o_PCPlus4D,
    output logic [ADDRESS_WIDTH-1:0]  o_PCD,
    output logic                      o_PCSrcD
);

    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [INSTR_WIDTH-1:0]   instr_d;
    logic [ADDRESS_WIDTH-1:0] pcplus4_q;
    logic [ADDRESS_WIDTH-1:0] pcplus4_d;

    logic [DATA_WIDTH-1:0]    cmp_a;
    logic [DATA_WIDTH-1:0]    cmp_b;
    logic                     cmp_eq;
    logic [ADDRESS_WIDTH-1:0] br_target;
    logic [ADDRESS_WIDTH-1:0] j_target;

    // Stall outranks the self-flush so a held branch is not lost.
    always_comb begin
        instr_d = instr_q;
        pcplus4_d = pcplus4_q;
        if (!i_StallD) begin
            if (o_PCSrcD) begin
                instr_d = NOP;
                pcplus4_d = '0;
            end else begin
                instr_d = i_InstrF;
                pcplus4_d = i_PCPlus4F;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            instr_q <= NOP;
            pcplus4_q <= '0;
        end else begin
            instr_q <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign o_OpD = instr_q[31:26];
    assign o_RsD = instr_q[25:21];
    assign o_RtD = instr_q[20:16];
    assign o_RdD = instr_q[15:11];
    assign o_FunctD = instr_q[5:0];
    assign o_SignImmD = sign_ext16(instr_q[15:0]);
    assign o_PCPlus4D = pcplus4_q;

    register_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rf (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_RA1 (o_RsD),
        .i_RA2 (o_RtD),
        .i_WE  (i_RegWriteW),
        .i_WA  (i_WriteRegW),
        .i_WD  (i_ResultW),
        .o_RD1 (o_RD1D),
        .o_RD2 (o_RD2D)
    );

    always_comb begin
        cmp_a = i_ForwardAD ? i_ALUOutM : o_RD1D;
        cmp_b = i_ForwardBD ? i_ALUOutM : o_RD2D;
        cmp_eq = (cmp_a == cmp_b);
    end

    assign o_PCSrcD = (i_BranchD & cmp_eq) | i_JumpD;

    assign br_target = pcplus4_q + {o_SignImmD[ADDRESS_WIDTH-3:0], 2'b00};
    assign j_target = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
    assign o_PCD = i_JumpD ? j_target : br_target;

endmodule
